// File: rtl/f2fix_pkg.sv
// Shared binary32 field layout and special exponent codes for the float-to-fixed converter.
package f2fix_pkg;

    localparam int SIGN_W      = 1;
    localparam int EXP_W       = 8;
    localparam int MAN_W       = 23;
    localparam int EXP_BIAS    = 127;
    localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'd255;

    typedef struct packed {
        logic [SIGN_W-1:0] sign;
        logic [EXP_W-1:0]  exp;
        logic [MAN_W-1:0]  man;
    } float32_t;

endpackage

// File: rtl/f2fix_core.sv
// Combinational binary32 to signed fixed-point conversion with rounding, saturation/wrap and flags.
// Subnormal inputs are converted exactly when F2FIX_SUBNORMAL_EN is defined, otherwise flushed to zero.
module f2fix_core
    import f2fix_pkg::*;
#(
    parameter int WOI   = 10,
    parameter int WOF   = 10,
    parameter int ROOF  = 1,
    parameter int ROUND = 1
) (
    input  logic [31:0]          float,
    output logic [WOI+WOF-1:0]   out,
    output logic                 upflow,
    output logic                 downflow
);

    localparam int N  = WOI + WOF;
    // Rounded-magnitude width: the left shift is clamped to N+1, so 24 significand bits plus N+2 never overflow.
    localparam int RW = N + 26;
    localparam logic [RW-1:0] POS_LIM = {{(RW-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic [RW-1:0] NEG_LIM = {{(RW-N){1'b0}}, 1'b1, {(N-1){1'b0}}};

    float32_t    f;
    logic        is_zero;
    logic        is_special;
    logic [23:0] sig;
    int          e_eff;
    int          sh;
    logic [RW:0] acc;
    logic [RW:0] shifted;
    logic [RW-1:0] r;
    logic [N-1:0]  signed_low;
    logic [N-1:0]  sat;
    logic          ovf;
`ifndef F2FIX_SUBNORMAL_EN
    logic          is_sub;
`endif

    assign f = float_to_struct(float);

    function automatic float32_t float_to_struct(input logic [31:0] v);
        return float32_t'(v);
    endfunction

    always_comb begin
        is_zero    = (f.exp == '0) && (f.man == '0);
        is_special = (f.exp == EXP_SPECIAL);
        sig        = (f.exp == '0) ? {1'b0, f.man} : {1'b1, f.man};
        e_eff      = (f.exp == '0) ? 1 : int'(f.exp);
        sh         = e_eff - EXP_BIAS - MAN_W + WOF;

        // Bit 0 of acc is the half-LSB position used for rounding after the shift.
        acc = {{(RW-24){1'b0}}, sig, 1'b0};
        if (sh >= 0) begin
            shifted = acc << ((sh > N + 1) ? (N + 1) : sh);
        end else begin
            shifted = acc >> ((-sh > 26) ? 26 : -sh);
        end
        r = shifted[RW:1] + (((ROUND != 0) && shifted[0]) ? RW'(1) : RW'(0));

        signed_low = f.sign[0] ? N'(RW'(0) - r) : r[N-1:0];
        ovf        = f.sign[0] ? (r > NEG_LIM) : (r > POS_LIM);
        sat        = f.sign[0] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};

        out      = '0;
        upflow   = 1'b0;
        downflow = 1'b0;
`ifndef F2FIX_SUBNORMAL_EN
        is_sub   = (f.exp == '0) && (f.man != '0);
`endif
        if (is_special) begin
            upflow = 1'b1;
            out    = (ROOF != 0) ? sat : '0;
        end else if (is_zero) begin
            out = '0;
`ifndef F2FIX_SUBNORMAL_EN
        end else if (is_sub) begin
            downflow = 1'b1;
`endif
        end else if (r == '0) begin
            downflow = 1'b1;
        end else if (ovf) begin
            upflow = 1'b1;
            out    = (ROOF != 0) ? sat : signed_low;
        end else begin
            out = signed_low;
        end
    end

endmodule

// File: rtl/comb_float32_to_fixed_point.sv
// Registered binary32 to fixed-point converter: one-cycle latency, one sample per clock, no handshake.
// Subnormal conversion is enabled by defining F2FIX_SUBNORMAL_EN.
module comb_float32_to_fixed_point
    import f2fix_pkg::*;
#(
    parameter int WOI   = 10,
    parameter int WOF   = 10,
    parameter int ROOF  = 1,
    parameter int ROUND = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          float,
    output logic [WOI+WOF-1:0]   out,
    output logic                 upflow,
    output logic                 downflow
);

    logic [WOI+WOF-1:0] core_out;
    logic               core_upflow;
    logic               core_downflow;

    f2fix_core #(
        .WOI   (WOI),
        .WOF   (WOF),
        .ROOF  (ROOF),
        .ROUND (ROUND)
    ) u_core (
        .float    (float),
        .out      (core_out),
        .upflow   (core_upflow),
        .downflow (core_downflow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out      <= '0;
            upflow   <= 1'b0;
            downflow <= 1'b0;
        end else begin
            out      <= core_out;
            upflow   <= core_upflow;
            downflow <= core_downflow;
        end
    end

endmodule

// File: tb/tb_comb_float32_to_fixed_point.sv
// Bench for comb_float32_to_fixed_point (WOI=10, WOF=10): directed and random floats against a real-arithmetic model.
module tb_comb_float32_to_fixed_point;

    logic        clk;
    logic        rst;
    logic [31:0] float;
    logic [19:0] out_d, out_w, out_t;
    logic        up_d, up_w, up_t;
    logic        dn_d, dn_w, dn_t;
    int          n_checks;
    int          n_pass;

    comb_float32_to_fixed_point #(.WOI(10), .WOF(10), .ROOF(1), .ROUND(1)) dut (
        .clk(clk), .rst(rst), .float(float), .out(out_d), .upflow(up_d), .downflow(dn_d));
    comb_float32_to_fixed_point #(.WOI(10), .WOF(10), .ROOF(0), .ROUND(1)) dut_wrap (
        .clk(clk), .rst(rst), .float(float), .out(out_w), .upflow(up_w), .downflow(dn_w));
    comb_float32_to_fixed_point #(.WOI(10), .WOF(10), .ROOF(1), .ROUND(0)) dut_trunc (
        .clk(clk), .rst(rst), .float(float), .out(out_t), .upflow(up_t), .downflow(dn_t));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact value from the fields in real arithmetic, then round, range-check and wrap.
    function automatic logic [21:0] model(input logic [31:0] f, input bit roof, input bit rnd);
        int          e;
        int          m;
        real         p;
        real         mag;
        real         r;
        real         res;
        longint      li;
        logic [19:0] o;
        logic [19:0] sat;
        e   = int'(f[30:23]);
        m   = int'(f[22:0]);
        sat = f[31] ? 20'h80000 : 20'h7FFFF;
        if (e == 255) return {(roof ? sat : 20'h0), 2'b10};
        if (e == 0 && m == 0) return 22'h0;
        if (e == 0) return {20'h0, 2'b01};
        p = 1.0;
        if (e >= 127) repeat (e - 127) p = p * 2.0;
        else repeat (127 - e) p = p / 2.0;
        mag = (1.0 + m / 8388608.0) * p * 1024.0;
        r   = rnd ? $floor(mag + 0.5) : $floor(mag);
        if (r == 0.0) return {20'h0, 2'b01};
        if (r > (f[31] ? 524288.0 : 524287.0)) begin
            if (roof) return {sat, 2'b10};
            res = r - $floor(r / 1048576.0) * 1048576.0;
            li  = longint'(res);
            o   = li[19:0];
            if (f[31]) o = -o;
            return {o, 2'b10};
        end
        li = longint'(r);
        o  = li[19:0];
        if (f[31]) o = -o;
        return {o, 2'b00};
    endfunction

    task automatic check(input string tag, input logic [21:0] obs, input logic [21:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed out/up/dn=%h/%b/%b expected %h/%b/%b",
                    tag, obs[21:2], obs[1], obs[0], exp[21:2], exp[1], exp[0]);
    endtask

    task automatic apply(input logic [31:0] f);
        @(negedge clk);
        float = f;
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag, input logic [31:0] f);
        check({tag, "/sat_rnd"},   {out_d, up_d, dn_d}, model(f, 1'b1, 1'b1));
        check({tag, "/wrap_rnd"},  {out_w, up_w, dn_w}, model(f, 1'b0, 1'b1));
        check({tag, "/sat_trunc"}, {out_t, up_t, dn_t}, model(f, 1'b1, 1'b0));
    endtask

    initial begin
        logic [31:0] f;
        logic [7:0]  e;
        n_checks = 0;
        n_pass   = 0;
        float    = 32'h0;
        rst      = 1'b0;
        #1 rst = 1'b1;
        #1 check("reset_init", {out_d, up_d, dn_d}, 22'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        apply(32'hc36f0d77); check("norm_c36f0d77", {out_d, up_d, dn_d}, {20'hC43CA, 2'b00});
        check_model("norm_c36f0d77", float);
        apply(32'hc19d957c); check("norm_c19d957c", {out_d, up_d, dn_d}, {20'hFB135, 2'b00});
        apply(32'h407e7564); check("norm_407e7564", {out_d, up_d, dn_d}, {20'h00FE7, 2'b00});

        apply(32'h44696e31); check("ovf_pos", {out_d, up_d, dn_d}, {20'h7FFFF, 2'b10});
        check_model("ovf_pos", float);
        apply(32'hc427f97f); check("ovf_neg", {out_d, up_d, dn_d}, {20'h80000, 2'b10});
        check_model("ovf_neg", float);

        apply(32'h00000000); check("pos_zero", {out_d, up_d, dn_d}, 22'h0);
        apply(32'h80000000); check("neg_zero", {out_d, up_d, dn_d}, 22'h0);
        apply(32'h7f800000); check("pos_inf", {out_d, up_d, dn_d}, {20'h7FFFF, 2'b10});
        check("pos_inf_wrap", {out_w, up_w, dn_w}, {20'h00000, 2'b10});
        apply(32'h7fc00000); check("nan", {out_d, up_d, dn_d}, {20'h7FFFF, 2'b10});
        apply(32'hff800000); check("neg_inf", {out_d, up_d, dn_d}, {20'h80000, 2'b10});

        apply(32'h33800000); check("udf_2m24", {out_d, up_d, dn_d}, {20'h0, 2'b01});
        apply(32'h3a000000); check("half_lsb_rnd", {out_d, up_d, dn_d}, {20'h00001, 2'b00});
        check("half_lsb_trunc", {out_t, up_t, dn_t}, {20'h0, 2'b01});
        apply(32'h00400000); check("subnormal", {out_d, up_d, dn_d}, {20'h0, 2'b01});
        apply(32'h44000000); check("max_neg_edge_pos", {out_d, up_d, dn_d}, {20'h7FFFF, 2'b10});
        apply(32'hc4000000); check("min_neg_exact", {out_d, up_d, dn_d}, {20'h80000, 2'b00});

        // Output must hold its previous value until the next rising edge.
        apply(32'h407e7564);
        @(negedge clk);
        float = 32'hc19d957c;
        #1 check("latency_hold", {out_d, up_d, dn_d}, {20'h00FE7, 2'b00});
        @(posedge clk);
        #1 check("latency_update", {out_d, up_d, dn_d}, {20'hFB135, 2'b00});

        // Asynchronous reset mid-stream.
        apply(32'h7f800000);
        #2 rst = 1'b1;
        #1 check("reset_async", {out_d, up_d, dn_d}, 22'h0);
        check("reset_async_wrap", {out_w, up_w, dn_w}, 22'h0);
        @(negedge clk);
        rst   = 1'b0;
        float = 32'hc36f0d77;
        @(posedge clk);
        #1 check("after_reset", {out_d, up_d, dn_d}, {20'hC43CA, 2'b00});

        for (int i = 0; i < 200; i++) begin
            e = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(105, 140));
            f = {1'($urandom_range(0, 1)), e, 23'($urandom)};
            apply(f);
            check_model($sformatf("rand_%0d_%h", i, f), f);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/comb_float32_to_fixed_point.md
COMB_FLOAT32_TO_FIXED_POINT -- requirements
Module: comb_float32_to_fixed_point

Interface
REQ-001 SHALL have parameter WOI, default 10: integer width of the output, sign bit included; legal range 2..32.
REQ-002 SHALL have parameter WOF, default 10: fractional width of the output; legal range 0..32.
REQ-003 SHALL have parameter ROOF, default 1: 1 = saturate on overflow, 0 = wrap.
REQ-004 SHALL have parameter ROUND, default 1: 1 = round to nearest, ties away from zero; 0 = truncate toward zero.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all outputs are registered on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port float, input, 32 bits: IEEE-754 binary32 operand.
REQ-008 SHALL have port out, output, WOI+WOF bits: signed two's-complement fixed-point result; value = out / 2^WOF.
REQ-009 SHALL have port upflow, output, 1 bit: overflow flag.
REQ-010 SHALL have port downflow, output, 1 bit: underflow flag.

Function
REQ-011 SHALL sample float on every rising clk edge; out/upflow/downflow reflect that sample one cycle later; latency 1, throughput 1/cycle; no handshake.
REQ-012 SHALL decode sign s, exponent e (8b, bias 127), mantissa m (23b); normal value = (-1)^s * 1.m * 2^(e-127).
REQ-013 SHALL compute magnitude M = |value| * 2^WOF with internal width sufficient for no loss before the rounding step.
REQ-014 SHALL round M: ROUND=1 adds half-LSB then truncates (ties away from zero); ROUND=0 truncates; the sign is applied after rounding.
REQ-015 SHALL flag upflow=1 when the signed rounded result is outside [-2^(WOI+WOF-1), 2^(WOI+WOF-1)-1].
REQ-016 SHALL, on upflow with ROOF=1, drive out = max positive (0111..1) if s=0, else min negative (1000..0); ROOF=0: out = low WOI+WOF bits of the signed result.
REQ-017 SHALL flag downflow=1 when the input is nonzero and the rounded result is 0; out = 0 in that case.
REQ-018 SHALL map +0 and -0 to out=0, upflow=0, downflow=0.
REQ-019 SHALL treat +/-Inf (e=255, m=0) as overflow: upflow=1, out saturated per sign (ROOF=1) or 0 (ROOF=0).
REQ-020 SHALL treat NaN (e=255, m!=0) like Inf of the same sign.
REQ-021 SHALL never assert upflow and downflow together.

Reset
REQ-022 SHALL, while rst=1, force out=0, upflow=0, downflow=0 immediately, independent of clk.
REQ-023 SHALL produce the result for the float sampled at the first rising clk after rst deasserts; there is no other internal state.

Configuration
REQ-024 SHALL, with macro F2FIX_SUBNORMAL_EN defined, convert subnormals (e=0, m!=0) exactly as 0.m * 2^-126 before rounding.
REQ-025 SHALL, without F2FIX_SUBNORMAL_EN, flush subnormals to out=0 with downflow=1.

Structure
REQ-026 SHALL place the binary32 field widths (1/8/23), exponent bias 127 and the Inf/NaN exponent code 255 in shared package f2fix_pkg.
REQ-027 SHALL implement the conversion as combinational sub-module f2fix_core (float in; out/upflow/downflow out), with the top holding only the output registers.

Verification (WOI=10, WOF=10, ROOF=1, ROUND=1, 20-bit out)
REQ-028 SHALL cover normal values: 0xc36f0d77 -> out=0xC43CA (-239.052734); 0xc19d957c -> 0xFB135; 0x407e7564 -> 0x00FE7; all with flags 0.
REQ-029 SHALL cover overflow: 0x44696e31 (933.7) -> 0x7FFFF, upflow=1; 0xc427f97f (-671.9) -> 0x80000, upflow=1; repeat with ROOF=0 -> wrapped low bits, upflow=1.
REQ-030 SHALL cover specials: 0x00000000 and 0x80000000 -> 0, no flags; 0x7f800000 and 0x7fc00000 -> 0x7FFFF, upflow=1; 0xff800000 -> 0x80000, upflow=1.
REQ-031 SHALL cover underflow: 0x33800000 (2^-24) -> out=0, downflow=1; 0x3a000000 (2^-11, ROUND=1) -> 0x00001, ROUND=0 -> 0, downflow=1.
REQ-032 SHALL cover timing and reset: output changes exactly one clk after input; asserting rst mid-stream clears out and both flags before the next clk edge.
